// File: rtl/aes_round_ctrl.sv
// Round sequencer for the pipelined AES encrypt datapath (AES-128/192/256).
// It runs a start/busy/done handshake and produces the round index, the key-expansion enable and the first/last-round flags.
module aes_round_ctrl #(
    parameter int RC_W   = 4,
    parameter int NR_128 = 10,
    parameter int NR_192 = 12,
    parameter int NR_256 = 14
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [1:0]      key_mode,
    input  logic            stall,
    input  logic            abort,
    output logic            key_gene_en,
    output logic [RC_W-1:0] round_count,
    output logic            round_valid,
    output logic            first_round,
    output logic            last_round,
    output logic            busy,
    output logic            done,
    output logic            err
);

    // state | meaning
    // IDLE  | waiting for start
    // LOAD  | round 0, initial AddRoundKey
    // RUN   | rounds 1..nr_q, one per non-stalled cycle
    // DONE  | one-cycle completion; a valid start restarts directly
    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_e;

    localparam logic [RC_W-1:0] NR128_C = RC_W'(NR_128);
    localparam logic [RC_W-1:0] NR192_C = RC_W'(NR_192);
    localparam logic [RC_W-1:0] NR256_C = RC_W'(NR_256);
    localparam logic [RC_W-1:0] ONE_C   = RC_W'(1);

    state_e          state_q;
    logic [RC_W-1:0] nr_q;
    logic [RC_W-1:0] nr_d;
    logic            mode_ok_d;

    always_comb begin
        nr_d      = NR128_C;
        mode_ok_d = 1'b1;
        case (key_mode)
            2'b00:   nr_d = NR128_C;
            2'b01:   nr_d = NR192_C;
            2'b10:   nr_d = NR256_C;
            default: mode_ok_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            nr_q        <= '0;
            key_gene_en <= 1'b0;
            round_count <= '0;
            round_valid <= 1'b0;
            first_round <= 1'b0;
            last_round  <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            if (abort) begin
                state_q     <= IDLE;
                key_gene_en <= 1'b0;
                round_count <= '0;
                round_valid <= 1'b0;
                first_round <= 1'b0;
                last_round  <= 1'b0;
                busy        <= 1'b0;
            end else if (stall && (state_q == LOAD || state_q == RUN)) begin
                // hold index and flags; only the per-cycle strobes drop
                round_valid <= 1'b0;
                key_gene_en <= 1'b0;
            end else begin
                case (state_q)
                    IDLE, DONE: begin
                        state_q     <= IDLE;
                        key_gene_en <= 1'b0;
                        round_count <= '0;
                        round_valid <= 1'b0;
                        first_round <= 1'b0;
                        last_round  <= 1'b0;
                        busy        <= 1'b0;
                        if (start) begin
                            if (mode_ok_d) begin
                                state_q     <= LOAD;
                                nr_q        <= nr_d;
                                key_gene_en <= 1'b1;
                                round_valid <= 1'b1;
                                first_round <= 1'b1;
                                busy        <= 1'b1;
                            end else begin
                                err <= 1'b1;
                            end
                        end
                    end
                    LOAD: begin
                        state_q     <= RUN;
                        round_count <= ONE_C;
                        key_gene_en <= 1'b1;
                        round_valid <= 1'b1;
                        first_round <= 1'b0;
                        last_round  <= (nr_q == ONE_C);
                        busy        <= 1'b1;
                    end
                    RUN: begin
                        if (round_count == nr_q) begin
                            state_q     <= DONE;
                            key_gene_en <= 1'b0;
                            round_count <= '0;
                            round_valid <= 1'b0;
                            first_round <= 1'b0;
                            last_round  <= 1'b0;
                            busy        <= 1'b0;
                            done        <= 1'b1;
                        end else begin
                            round_count <= round_count + ONE_C;
                            key_gene_en <= 1'b1;
                            round_valid <= 1'b1;
                            last_round  <= ((round_count + ONE_C) == nr_q);
                            busy        <= 1'b1;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: doc/aes_round_ctrl.md
# aes_round_ctrl

Parametrised round controller for the pipelined AES encryption datapath. It supports AES-128, AES-192 and AES-256 through a per-operation key-size select. Each operation uses a start/busy/done handshake and produces the round counter, key-expansion enable and first/last-round flags that drive the round and key-generation stages. It adds stall, abort and back-to-back restart.

## Interface
Parameters:
- RC_W, 4: round_count width; must be ≥ clog2(NR_256+1).
- NR_128, 10: final round index for AES-128.
- NR_192, 12: final round index for AES-192.
- NR_256, 14: final round index for AES-256.

Ports:
- clk  input  1  single clock; all logic on its rising edge.
- rst  input  1  reset; synchronous, active-low; sampled on the rising edge of clk.
- start  input  1  request a new operation.
- key_mode  input  2  key size: 00 = 128, 01 = 192, 10 = 256, 11 = reserved.
- stall  input  1  freeze progress for this cycle.
- abort  input  1  cancel the current operation.
- key_gene_en  output  1  key expansion advance enable.
- round_count  output  RC_W  current round index, 0..Nr.
- round_valid  output  1  round_count is live and must be consumed this cycle.
- first_round  output  1  round 0 (initial AddRoundKey).
- last_round  output  1  round Nr (no MixColumns).
- busy  output  1  operation in progress.
- done  output  1  one-cycle completion pulse.
- err  output  1  one-cycle pulse; start was rejected because key_mode = 11.

## Operation
- All outputs are registered. Every output is 0 in reset.
- States: IDLE, LOAD, RUN, DONE. Reset enters IDLE.
- Priority at each edge is rst, then abort, then stall, then normal flow.

IDLE:
- start with valid key_mode → LOAD. key_mode is latched into nr_q, which holds NR_128, NR_192 or NR_256.
- start with key_mode = 11 → remain in IDLE and pulse err for one cycle.

LOAD:
- round_count = 0, first_round = 1, round_valid = 1, key_gene_en = 1, busy = 1.
- Next state is RUN with round_count = 1.

RUN:
- Each non-stalled cycle presents one round: round_valid = 1, key_gene_en = 1, busy = 1.
- last_round = 1 when round_count == nr_q.
- After the last round is presented → DONE. Otherwise round_count increments by 1.
- The counter never wraps. The comparison uses the latched nr_q; key_mode changes mid-operation are ignored.

Stall (LOAD or RUN):
- State, round_count and all flags hold their values.
- round_valid = 0 and key_gene_en = 0 for that cycle.
- busy stays 1.

DONE:
- done = 1 for exactly one cycle. busy = 0, round_count = 0, all flags 0.
- start in DONE behaves as start in IDLE. A valid start goes directly to LOAD, so operations run back-to-back with no idle bubble.
- Otherwise → IDLE.

Abort:
- From LOAD, RUN or DONE, the next state is IDLE and all outputs clear.
- No done pulse is produced.
- abort together with start in IDLE or DONE → IDLE; the start is dropped.

Other rules:
- start while busy is ignored; there is no queueing.
- Reset asserted mid-operation → IDLE with all outputs 0 at that edge.
- Operation resumes only when rst is sampled high and a new start arrives.

## Timing
- start sampled at edge E0 → LOAD visible after E0 (cycle 1).
- Rounds 1..Nr occupy cycles 2..Nr+1. done is high in cycle Nr+2.
- Without stall, start-to-done latency is 12 cycles for AES-128, 14 for AES-192 and 16 for AES-256.
- Each stalled cycle adds exactly one cycle of latency.
- key_gene_en is asserted in the same cycle as the round it serves.
- err and done are never high together. busy and done are never high together.

## Test plan
- Reset, AES-128: rst low for 2 cycles, then start with key_mode = 00 → round_count runs 0..10 in cycles 1..11. first_round is high only at round 0, last_round only at round 10, done at cycle 12. All outputs are 0 during reset.
- Mode sweep: key_mode = 01, then 10 → last_round at round 12 and 14 respectively, done at cycles 14 and 16. Flipping key_mode mid-run to 00 has no effect.
- Stall: assert stall for 3 cycles at round 5 (AES-128) → round_count holds at 5 while round_valid = 0 and key_gene_en = 0. done moves to cycle 15.
- Abort: abort at round 7 (AES-256) → next cycle IDLE, all outputs 0, no done pulse. abort together with start in IDLE → stays IDLE.
- Back-to-back and reject: start held high through DONE → the next LOAD is in the cycle right after done. start with key_mode = 11 → one-cycle err, busy stays 0.
- Reset mid-run: rst low at round 4 → outputs 0 at the next edge. start while busy is ignored.
